// File: rtl/uart_poke_pkg.sv
// Shared types and framing constants for the UART poke loader.
// Frame: sync, id, addr[4] LE, data[4] LE, xor checksum.
package uart_poke_pkg;

    typedef enum logic [2:0] {
        SYNC,
        ID,
        ADDR,
        DATA,
        CSUM,
        POKE,
        REPLY
    } poke_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam int         FRAME_LEN = 11;

endpackage

// File: rtl/poke_frame_timer.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled.
// expired is high once the count has run out.
module poke_frame_timer #(
    parameter int TIMEOUT = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= W'(TIMEOUT);
        end else if (enable && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/uart_poke_loader.sv
// Parses framed UART bytes into single-word memory pokes and
// answers every decoded frame with one ACK/NAK status byte.
module uart_poke_loader
    import uart_poke_pkg::*;
#(
    parameter int RN         = 16,
    parameter int ADDR_DEPTH = 1024,
    parameter int TIMEOUT    = 2_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rxData,
    input  logic                  rxValid,
    output logic [$clog2(RN)-1:0] pokeId,
    output logic [31:0]           pokeAddress,
    output logic [31:0]           pokeData,
    output logic                  pokeValid,
    input  logic                  pokeReady,
    output logic [7:0]            txData,
    output logic                  txValid,
    input  logic                  txReady,
    output logic                  busy
);

    localparam int IW = $clog2(RN);

    poke_state_t state;
    poke_state_t stateNext;

    logic [7:0] idByte;
    logic [7:0] xorAcc;
    logic [1:0] byteCnt;
    logic       inFrame;
    logic       timedOut;
    logic       frameGood;
    logic       pokeValidD;
    logic       txValidD;
    logic       busyD;

    assign inFrame = state inside {ID, ADDR, DATA, CSUM};

    // Range checks use the full id byte and full 32-bit address.
    assign frameGood = (xorAcc == rxData)
                    && ({24'd0, idByte} < 32'(RN))
                    && (pokeAddress < 32'(ADDR_DEPTH));

    poke_frame_timer #(
        .TIMEOUT(TIMEOUT)
    ) uTimer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rxValid),
        .enable (inFrame),
        .expired(timedOut)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SYNC;
            pokeValid <= 1'b0;
            txValid   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            pokeValid <= pokeValidD;
            txValid   <= txValidD;
            busy      <= busyD;
        end
    end

    // A byte arriving in the same cycle the timer runs out wins.
    always_comb begin
        stateNext = state;
        unique case (state)
            SYNC: if (rxValid && rxData == SYNC_BYTE) stateNext = ID;
            ID: begin
                if (rxValid) stateNext = ADDR;
                else if (timedOut) stateNext = SYNC;
            end
            ADDR: begin
                if (rxValid) begin
                    if (byteCnt == 2'd3) stateNext = DATA;
                end else if (timedOut) begin
                    stateNext = SYNC;
                end
            end
            DATA: begin
                if (rxValid) begin
                    if (byteCnt == 2'd3) stateNext = CSUM;
                end else if (timedOut) begin
                    stateNext = SYNC;
                end
            end
            CSUM: begin
                if (rxValid) stateNext = frameGood ? POKE : REPLY;
                else if (timedOut) stateNext = SYNC;
            end
            POKE:  if (pokeValid && pokeReady) stateNext = REPLY;
            REPLY: if (txValid && txReady) stateNext = SYNC;
            default: stateNext = SYNC;
        endcase
    end

    always_comb begin
        pokeValidD = (stateNext == POKE);
        txValidD   = (stateNext == REPLY);
        busyD      = (stateNext != SYNC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idByte      <= '0;
            xorAcc      <= '0;
            byteCnt     <= '0;
            pokeId      <= '0;
            pokeAddress <= '0;
            pokeData    <= '0;
            txData      <= '0;
        end else begin
            if (rxValid) begin
                unique case (state)
                    SYNC: begin
                        xorAcc  <= '0;
                        byteCnt <= '0;
                    end
                    ID: begin
                        idByte <= rxData;
                        pokeId <= rxData[IW-1:0];
                        xorAcc <= xorAcc ^ rxData;
                    end
                    ADDR: begin
                        pokeAddress <= {rxData, pokeAddress[31:8]};
                        xorAcc      <= xorAcc ^ rxData;
                        byteCnt     <= byteCnt + 2'd1;
                    end
                    DATA: begin
                        pokeData <= {rxData, pokeData[31:8]};
                        xorAcc   <= xorAcc ^ rxData;
                        byteCnt  <= byteCnt + 2'd1;
                    end
                    CSUM: if (!frameGood) txData <= NAK_BYTE;
                    default: ;
                endcase
            end
            if (state == POKE && pokeValid && pokeReady) begin
                txData <= ACK_BYTE;
            end
        end
    end

endmodule

// File: tb/tb_uart_poke_loader.sv
// Bench for uart_poke_loader: frame table, scoreboard of expected
// pokes/replies, plus backpressure, timeout, garbage and reset cases.
module tb_uart_poke_loader;
    import uart_poke_pkg::*;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxData;
    logic        rxValid;
    logic [3:0]  pokeId;
    logic [31:0] pokeAddress;
    logic [31:0] pokeData;
    logic        pokeValid;
    logic        pokeReady;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        busy;

    uart_poke_loader #(
        .RN(16),
        .ADDR_DEPTH(1024),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxData     (rxData),
        .rxValid    (rxValid),
        .pokeId     (pokeId),
        .pokeAddress(pokeAddress),
        .pokeData   (pokeData),
        .pokeValid  (pokeValid),
        .pokeReady  (pokeReady),
        .txData     (txData),
        .txValid    (txValid),
        .txReady    (txReady),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          isPoke;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  tx;
    } evt_t;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  corrupt;
        bit          expPoke;
        logic [7:0]  expTx;
    } vec_t;

    evt_t sb[$];
    evt_t monE;
    vec_t vecs[9];
    int   nChecks = 0;
    int   nFail = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (pokeValid && pokeReady) begin
            if (sb.size() == 0 || !sb[0].isPoke) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected poke: id %h addr %h data %h",
                         pokeId, pokeAddress, pokeData);
            end else begin
                monE = sb.pop_front();
                check("pokeId", 32'(pokeId), 32'(monE.id));
                check("pokeAddress", pokeAddress, monE.addr);
                check("pokeData", pokeData, monE.data);
            end
        end
        if (txValid && txReady) begin
            if (sb.size() == 0 || sb[0].isPoke) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected reply: got %h want none", txData);
            end else begin
                monE = sb.pop_front();
                check("txData", 32'(txData), 32'(monE.tx));
            end
        end
    end

    function automatic logic [7:0] csumOf(input logic [7:0] id,
                                          input logic [31:0] a,
                                          input logic [31:0] d);
        return id ^ a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24]
                  ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
    endfunction

    task automatic sendByte(input logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] id, input logic [31:0] a,
                             input logic [31:0] d, input logic [7:0] corrupt,
                             input int gap);
        logic [7:0] f[FRAME_LEN];
        f[0] = SYNC_BYTE;
        f[1] = id;
        for (int i = 0; i < 4; i++) f[2 + i] = a[8*i +: 8];
        for (int i = 0; i < 4; i++) f[6 + i] = d[8*i +: 8];
        f[10] = csumOf(id, a, d) ^ corrupt;
        for (int i = 0; i < FRAME_LEN; i++) begin
            sendByte(f[i]);
            if (i == 1) repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic expectFrame(input logic [7:0] id, input logic [31:0] a,
                               input logic [31:0] d, input bit doPoke,
                               input logic [7:0] tx);
        if (doPoke) sb.push_back('{1'b1, id[3:0], a, d, 8'h00});
        sb.push_back('{1'b0, 4'h0, 32'h0, 32'h0, tx});
    endtask

    task automatic waitIdle(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rxData    = 8'h00;
        rxValid   = 1'b0;
        pokeReady = 1'b1;
        txReady   = 1'b1;

        vecs[0] = '{8'h07, 32'h0000_0123, 32'hDEAD_BEEF, 8'h00, 1'b1, ACK_BYTE};
        vecs[1] = '{8'h07, 32'h0000_0123, 32'hDEAD_BEEF, 8'h0F, 1'b0, NAK_BYTE};
        vecs[2] = '{8'h10, 32'h0000_0123, 32'hDEAD_BEEF, 8'h00, 1'b0, NAK_BYTE};
        vecs[3] = '{8'h07, 32'h0000_0400, 32'hDEAD_BEEF, 8'h00, 1'b0, NAK_BYTE};
        vecs[4] = '{8'h0F, 32'h0000_03FF, 32'h0BAD_F00D, 8'h00, 1'b1, ACK_BYTE};
        vecs[5] = '{8'h02, 32'h1000_0005, 32'h1111_2222, 8'h00, 1'b0, NAK_BYTE};
        vecs[6] = '{8'h87, 32'h0000_0010, 32'h3333_4444, 8'h00, 1'b0, NAK_BYTE};
        vecs[7] = '{8'h00, 32'h0000_0000, 32'h0000_0000, 8'h00, 1'b1, ACK_BYTE};
        vecs[8] = '{8'h03, 32'h0000_002A, 32'h1234_5678, 8'h00, 1'b1, ACK_BYTE};

        repeat (2) @(posedge clk);
        #1;
        check("rst pokeValid", 32'(pokeValid), 32'd0);
        check("rst txValid", 32'(txValid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst pokeId", 32'(pokeId), 32'd0);
        check("rst pokeAddress", pokeAddress, 32'd0);
        check("rst pokeData", pokeData, 32'd0);
        check("rst txData", 32'(txData), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 9; v++) begin
            expectFrame(vecs[v].id, vecs[v].addr, vecs[v].data,
                        vecs[v].expPoke, vecs[v].expTx);
            sendFrame(vecs[v].id, vecs[v].addr, vecs[v].data,
                      vecs[v].corrupt, 0);
            check("csum+1 pokeValid", 32'(pokeValid), 32'(vecs[v].expPoke));
            check("csum+1 txValid", 32'(txValid), 32'(!vecs[v].expPoke));
            waitIdle(30, "table frame done");
        end

        // Backpressure with bytes injected while the poke is stalled.
        pokeReady = 1'b0;
        txReady   = 1'b0;
        expectFrame(8'h07, 32'h123, 32'hDEADBEEF, 1'b1, ACK_BYTE);
        sendFrame(8'h07, 32'h123, 32'hDEADBEEF, 8'h00, 0);
        for (int i = 0; i < 20; i++) begin
            rxData  = (i % 2 == 0) ? SYNC_BYTE : (8'h5A ^ 8'(i));
            rxValid = 1'b1;
            check("bp pokeValid", 32'(pokeValid), 32'd1);
            check("bp txValid", 32'(txValid), 32'd0);
            check("bp pokeAddress", pokeAddress, 32'h123);
            check("bp pokeData", pokeData, 32'hDEADBEEF);
            check("bp pokeId", 32'(pokeId), 32'd7);
            @(posedge clk);
            #1;
        end
        rxValid   = 1'b0;
        pokeReady = 1'b1;
        @(posedge clk);
        #1;
        check("poke+1 pokeValid", 32'(pokeValid), 32'd0);
        check("poke+1 txValid", 32'(txValid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp txValid hold", 32'(txValid), 32'd1);
            check("bp txData hold", 32'(txData), 32'(ACK_BYTE));
            @(posedge clk);
            #1;
        end
        txReady = 1'b1;
        waitIdle(10, "bp done");
        expectFrame(8'h05, 32'h77, 32'hCAFE0001, 1'b1, ACK_BYTE);
        sendFrame(8'h05, 32'h77, 32'hCAFE0001, 8'h00, 0);
        waitIdle(30, "after bp frame");

        // Partial frame left to time out.
        sendByte(SYNC_BYTE);
        sendByte(8'h07);
        sendByte(8'h23);
        repeat (TO / 2) @(posedge clk);
        #1;
        check("timeout mid busy", 32'(busy), 32'd1);
        repeat (TO) @(posedge clk);
        #1;
        check("timeout busy", 32'(busy), 32'd0);
        expectFrame(8'h07, 32'h123, 32'hDEADBEEF, 1'b1, ACK_BYTE);
        sendFrame(8'h07, 32'h123, 32'hDEADBEEF, 8'h00, 0);
        waitIdle(30, "after timeout frame");

        // A gap just short of the timeout keeps the frame alive.
        expectFrame(8'h09, 32'h200, 32'h55AA55AA, 1'b1, ACK_BYTE);
        sendFrame(8'h09, 32'h200, 32'h55AA55AA, 8'h00, TO - 3);
        waitIdle(30, "long gap frame");

        sendByte(8'h00);
        sendByte(8'hFF);
        sendByte(8'h5A);
        check("garbage busy", 32'(busy), 32'd0);
        expectFrame(8'h01, 32'h3FE, 32'h0000_0042, 1'b1, ACK_BYTE);
        sendFrame(8'h01, 32'h3FE, 32'h0000_0042, 8'h00, 0);
        waitIdle(30, "garbage frame");

        // Reset while a poke is pending: nothing must follow.
        pokeReady = 1'b0;
        sendFrame(8'h04, 32'h10, 32'h99, 8'h00, 0);
        repeat (2) @(posedge clk);
        #1;
        check("pre-rst pokeValid", 32'(pokeValid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst pokeValid", 32'(pokeValid), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pokeReady = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post-rst txValid", 32'(txValid), 32'd0);
        check("post-rst busy", 32'(busy), 32'd0);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/uart_poke_loader.md
# uart_poke_loader

Write-side counterpart of the peek path. It parses framed bytes from the UART receiver and issues single-word writes ("pokes") into a core's local memory inside `noc_with_cores`. Each frame gets one status byte back to the UART transmitter. It sits between `uart` (rxData/txData side) and the NoC memory poke port, mirroring the peekId/peekAddress/peekData read interface.

## Interface
Parameters:
- `RN`, 16: number of routers/cores; `pokeId` width is `$clog2(RN)`.
- `ADDR_DEPTH`, 1024: words per core memory; any address at or above this is rejected.
- `TIMEOUT`, 2_000_000: idle clk cycles allowed between bytes inside a frame.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rxData`  in  8  received byte.
- `rxValid`  in  1  one-cycle strobe; `rxData` is valid in that cycle.
- `pokeId`  out  $clog2(RN)  target core.
- `pokeAddress`  out  32  word address in the target memory.
- `pokeData`  out  32  write data.
- `pokeValid`  out  1  write request.
- `pokeReady`  in  1  write accepted when sampled high together with `pokeValid`.
- `txData`  out  8  status byte.
- `txValid`  out  1  status byte valid.
- `txReady`  in  1  transmitter accepts the byte when high together with `txValid`.
- `busy`  out  1  high in every state except SYNC.

## Operation
- Frame format, 11 bytes:
  - `0xA5` sync byte.
  - id byte.
  - address, 4 bytes, little-endian.
  - data, 4 bytes, little-endian.
  - checksum byte = XOR of id, address and data bytes (sync byte excluded).
- States: SYNC → ID → ADDR → DATA → CSUM → POKE → REPLY → SYNC.
- SYNC: bytes other than `0xA5` are discarded.
- ID, ADDR, DATA: on each `rxValid`, store the byte, update the running XOR and step a 2-bit byte counter.
  - ADDR and DATA each leave after their 4th byte.
- CSUM: on `rxValid`, decide the frame:
  - **Good frame:** checksum matches, id < RN, and address < ADDR_DEPTH. Go to POKE.
  - **Otherwise:** load NAK (`0x15`) and go straight to REPLY.
- POKE: `pokeValid` high with `pokeId`, `pokeAddress` and `pokeData` stable. On `pokeValid && pokeReady`, load ACK (`0x06`) and go to REPLY.
- REPLY: `txValid` high with `txData` stable. On `txValid && txReady`, return to SYNC.
- `rxValid` during POKE or REPLY: the byte is dropped. There is no rx backpressure.
- Inter-byte timeout: in ID, ADDR, DATA or CSUM, the timer counts idle cycles and reloads on every `rxValid`.
  - When it reaches TIMEOUT, go to SYNC silently: no poke, no reply.
  - If `rxValid` arrives in the same cycle the timer expires, the byte wins.
- Arithmetic: the address is held as a full 32 bits; the range check uses all 32 bits, so upper bits that are set cause a NAK. The id check uses all 8 bits of the id byte.

## Timing
- Reset values:
  - state SYNC;
  - `pokeValid`, `txValid` and `busy` all 0;
  - `pokeId`, `pokeAddress`, `pokeData` and `txData` all 0;
  - XOR accumulator, byte counter and timer cleared.
- Reset mid-frame or mid-handshake drops everything immediately; no reply is sent.
- All outputs are registered.
- Checksum byte accepted at cycle N:
  - good frame: `pokeValid` high at N+1;
  - bad frame: `txValid` high at N+1.
- Poke accepted at cycle M: `pokeValid` low at M+1 and `txValid` high at M+1.
- Minimum frame turnaround with `pokeReady` and `txReady` tied high: 2 cycles after the checksum byte.
- Payload may change only in the cycle after a handshake completes.

## Structure
- `uart_poke_pkg` holds:
  - the state enum `poke_state_t`;
  - `SYNC_BYTE = 8'hA5`, `ACK_BYTE = 8'h06`, `NAK_BYTE = 8'h15`, `FRAME_LEN = 11`.
- One sub-module, `poke_frame_timer`: loadable down-counter with inputs `clk`, `rst`, `clear`, `enable` and a single output `expired`.
- Main FSM and datapath live in `uart_poke_loader`.

## Test plan
- **Valid frame.** Send `A5 07 23 01 00 00 EF BE AD DE 07`.
  - Expect one poke with id 7, address `0x123`, data `0xDEADBEEF`, followed by `txData = 0x06`.
- **Bad checksum.** Send the same frame with checksum `0x08`.
  - Expect no `pokeValid`, and `txData = 0x15` one cycle after the checksum byte.
- **Out-of-range id and address.**
  - id `0x10` → NAK.
  - address `0x400` (bytes `00 04 00 00`) → NAK.
  - Neither case pokes.
- **Backpressure.** Hold `pokeReady` low for 20 cycles, then `txReady` low for 10 cycles.
  - Payload stays stable throughout; exactly one poke and one ACK occur.
  - Bytes injected during POKE are ignored, and the next frame parses correctly.
- **Timeout, garbage and reset.**
  - Send `A5 07 23`, then idle for TIMEOUT cycles. Expect a return to SYNC with no reply, and the next full frame ACKs.
  - Leading garbage `00 FF 5A` before a frame is skipped.
  - Assert `rst` during POKE: `pokeValid` drops to 0 asynchronously and no reply is sent.
